dma_burst_splitter: RTL and testbench
=====================================

# dma_burst_splitter

Upstream client of the memory arbiter. Accepts one transfer descriptor (direction, 8-byte-aligned byte address, length in 64-bit words) and issues it to one arbiter client port as a sequence of bursts. Each burst is at most MAX_BURST words and never crosses a PAGE_BYTES boundary. Alongside each burst it reports that burst's word offset within the transfer, so the owning engine can present or collect the matching slice of its data buffer. Data itself does not pass through this block.

## Interface

Parameters:
- MAX_BURST, 8192: maximum words per burst; equals the arbiter's data-array depth.
- PAGE_BYTES, 65536: burst boundary in bytes; power of two, multiple of 8, and ≥ 8.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  block idle; descriptor is accepted when cmd_valid && cmd_ready.
- cmd_rw  in  1  0 = read, 1 = write.
- cmd_addr  in  48  start byte address.
- cmd_len  in  32  transfer length in 64-bit words.
- mem_req  out  1  burst request to the arbiter client port.
- mem_rw  out  1  burst direction.
- mem_addr  out  48  burst start byte address.
- mem_len  out  32  burst length in words.
- mem_ack  in  1  one-cycle completion pulse from the arbiter.
- buf_off  out  32  word offset of the current burst within the transfer.
- burst_done  out  1  one-cycle pulse after each acked burst.
- done  out  1  one-cycle pulse at transfer end.
- err  out  1  one-cycle pulse when a descriptor is rejected.

## Operation

- States: IDLE, CALC, REQ, FIN.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch rw, cur_addr = cmd_addr, remaining = cmd_len, buf_off = 0.
  - If cmd_addr[2:0] != 0: pulse err the next cycle, stay in IDLE, issue no burst.
  - Else if cmd_len == 0: go to FIN; no burst is issued.
  - Else: go to CALC.
- CALC computes and registers the burst length:
  - page_left = (PAGE_BYTES − (cur_addr mod PAGE_BYTES)) / 8.
  - mem_len = min(remaining, MAX_BURST, page_left).
  - Next state: REQ.
- REQ:
  - mem_req = (state == REQ) && !mem_ack. This is combinational, so mem_req is never high in an ack cycle and the arbiter cannot re-service the same burst.
  - mem_rw, mem_addr, mem_len and buf_off stay stable for the whole of REQ.
- On the mem_ack cycle in REQ:
  - cur_addr += mem_len × 8 (48-bit wrap).
  - remaining −= mem_len.
  - buf_off += mem_len.
  - burst_done pulses the next cycle.
  - Next state: FIN if remaining reaches 0, else CALC.
- FIN: done = 1 for one cycle, then IDLE.
- mem_ack outside REQ is ignored.
- cmd_valid outside IDLE is ignored; cmd_ready = 0 there.
- Transfers have no abort. Only rst cancels a transfer, and the arbiter is reset together with this block.

## Timing

- Reset values:
  - cmd_ready = 1.
  - mem_req, burst_done, done, err = 0.
  - mem_rw = 0, mem_addr = 0, mem_len = 0, buf_off = 0.
  - State = IDLE.
- rst mid-transfer: at the next edge all outputs take their reset values and any in-flight burst is abandoned.
- Accept at edge t:
  - CALC during cycle t+1.
  - mem_req high from cycle t+2.
- With this arbiter, mem_ack arrives no earlier than 2 cycles after mem_req rises.
- Ack in cycle a:
  - burst_done is high in cycle a+1.
  - Next burst: CALC in cycle a+1, mem_req high in cycle a+2.
  - Last burst: done is high in cycle a+1 and cmd_ready is high in cycle a+2.
- Zero-length descriptor accepted at edge t: done is high in cycle t+1 and cmd_ready is high in cycle t+2.
- Misaligned descriptor accepted at edge t: err is high in cycle t+1; cmd_ready stays 1 throughout.
- Widths:
  - Internal length arithmetic is 32-bit unsigned; page_left never exceeds PAGE_BYTES/8.
  - buf_off equals the total words already acked.

## Test plan

- Zero length: addr 0x1000, len 0 -> done pulses; mem_req never rises; no burst_done.
- Single burst: write, addr 0x2000, len 16 -> one request with mem_len = 16, mem_addr = 0x2000, buf_off = 0; done pulses the cycle after ack.
- Size split: read, addr 0, len 20000 -> three bursts:
  - len 8192, addr 0x0, buf_off 0;
  - len 8192, addr 0x10000, buf_off 8192;
  - len 3616, addr 0x20000, buf_off 16384;
  - three burst_done pulses, then one done pulse.
- Page split: addr 0xFFF8, len 3 -> two bursts:
  - 1 word at 0xFFF8, buf_off 0;
  - 2 words at 0x10000, buf_off 1.
- Handshake: ack driven 2 cycles and 7 cycles after req -> req is low in the ack cycle; each burst is serviced exactly once by the real arbiter with both clients active.
- Error and reset:
  - addr 0x4 -> err pulses and no request is issued.
  - rst asserted while mem_req is high -> mem_req is 0 and cmd_ready is 1 the cycle after the reset edge.

Source files
------------

// File: rtl/dma_burst_splitter.sv
// dma_burst_splitter: takes one transfer descriptor and issues it to a memory
// arbiter client port as a series of bursts. Each burst is at most MAX_BURST
// words and never crosses a PAGE_BYTES boundary. buf_off tells the owning
// engine which slice of its data buffer belongs to the current burst.
//
// Handshakes:
//   cmd: a descriptor transfers on a cycle where cmd_valid && cmd_ready. The
//        fields are sampled only in that cycle. cmd_ready is high exactly
//        when the block is idle.
//   mem: mem_req stays high until the arbiter returns a one-cycle mem_ack.
//        mem_req is masked combinationally by mem_ack, so it is low in the
//        ack cycle. mem_rw, mem_addr, mem_len and buf_off do not change while
//        the request is pending.
module dma_burst_splitter #(
  parameter int unsigned MAX_BURST  = 8192,
  parameter int unsigned PAGE_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [47:0] cmd_addr,
  input  logic [31:0] cmd_len,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [47:0] mem_addr,
  output logic [31:0] mem_len,
  input  logic        mem_ack,
  output logic [31:0] buf_off,
  output logic        burst_done,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] REQ  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]  state;
  logic [47:0] cur_addr;
  logic [31:0] remaining;
  logic [31:0] len_q;
  logic [31:0] off_q;
  logic        rw_q;
  logic        burst_done_q;
  logic        err_q;

  logic [47:0] page_off;
  logic [31:0] page_left;
  logic [31:0] burst_len;

  // Next burst length: limited by the words still owed, MAX_BURST, and the
  // words left before the next page boundary.
  always_comb begin
    page_off  = cur_addr & (48'(PAGE_BYTES) - 48'd1);
    page_left = 32'((48'(PAGE_BYTES) - page_off) >> 3);
    burst_len = remaining;
    if (burst_len > 32'(MAX_BURST)) burst_len = 32'(MAX_BURST);
    if (burst_len > page_left)      burst_len = page_left;
  end

  // Descriptor capture, burst sequencing and the bookkeeping done on each ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur_addr     <= '0;
      remaining    <= '0;
      len_q        <= '0;
      off_q        <= '0;
      rw_q         <= 1'b0;
      burst_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      err_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rw_q      <= cmd_rw;
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            off_q     <= '0;
            if (cmd_addr[2:0] != 3'd0) begin
              err_q <= 1'b1;
            end else if (cmd_len == 32'd0) begin
              state <= FIN;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          len_q <= burst_len;
          state <= REQ;
        end
        REQ: begin
          if (mem_ack) begin
            cur_addr     <= cur_addr + 48'({len_q, 3'b000});
            remaining    <= remaining - len_q;
            off_q        <= off_q + len_q;
            burst_done_q <= 1'b1;
            state        <= (remaining == len_q) ? FIN : CALC;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs: the request is masked by the ack so one burst is never serviced twice.
  always_comb begin
    cmd_ready  = (state == IDLE);
    mem_req    = (state == REQ) && !mem_ack;
    mem_rw     = rw_q;
    mem_addr   = cur_addr;
    mem_len    = len_q;
    buf_off    = off_q;
    burst_done = burst_done_q;
    done       = (state == FIN);
    err        = err_q;
  end

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Directed bench for dma_burst_splitter. An ack responder embedded in the
// transfer task pulses mem_ack a chosen number of cycles after each request is seen.
module tb_dma_burst_splitter;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [47:0] cmd_addr;
  logic [31:0] cmd_len;
  logic        mem_req;
  logic        mem_rw;
  logic [47:0] mem_addr;
  logic [31:0] mem_len;
  logic        mem_ack;
  logic [31:0] buf_off;
  logic        burst_done;
  logic        done;
  logic        err;

  int n_checks;
  int n_fail;
  int req_cycles;
  int bd_count;

  logic [47:0] exp_addr_q[$];
  logic [31:0] exp_len_q[$];
  logic [31:0] exp_off_q[$];

  dma_burst_splitter dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rw     (cmd_rw),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .mem_req    (mem_req),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_len    (mem_len),
    .mem_ack    (mem_ack),
    .buf_off    (buf_off),
    .burst_done (burst_done),
    .done       (done),
    .err        (err)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // Activity counters sampled on the falling edge
  always @(negedge clk) begin
    if (mem_req)    req_cycles++;
    if (burst_done) bd_count++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_burst(input logic [47:0] a, input logic [31:0] l, input logic [31:0] o);
    exp_addr_q.push_back(a);
    exp_len_q.push_back(l);
    exp_off_q.push_back(o);
  endtask

  // Present one descriptor; returns just after the accepting edge.
  task automatic send_cmd(input logic rw, input logic [47:0] addr, input logic [31:0] len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = 48'h0;
    cmd_len   = 32'h0;
  endtask

  // Run a full transfer against the expected burst queues, acking each
  // request 'delay' cycles after it is first seen.
  task automatic run_xfer(input logic rw, input logic [47:0] addr, input logic [31:0] len,
                          input int delay);
    int nb;
    int cnt;
    logic [47:0] ea;
    logic [31:0] el;
    logic [31:0] eo;
    nb = exp_len_q.size();
    send_cmd(rw, addr, len);
    for (int b = 0; b < nb; b++) begin
      cnt = 0;
      @(negedge clk);
      while (!mem_req && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      check_eq("req_seen", mem_req, 1'b1);
      check_eq("req_latency", cnt, (b == 0) ? 1 : 0);
      ea = exp_addr_q.pop_front();
      el = exp_len_q.pop_front();
      eo = exp_off_q.pop_front();
      check_eq("mem_addr", mem_addr, ea);
      check_eq("mem_len", mem_len, el);
      check_eq("buf_off", buf_off, eo);
      check_eq("mem_rw", mem_rw, rw);
      check_eq("cmd_ready_busy", cmd_ready, 1'b0);
      repeat (delay) @(negedge clk);
      check_eq("req_held", mem_req, 1'b1);
      check_eq("mem_addr_stable", mem_addr, ea);
      check_eq("mem_len_stable", mem_len, el);
      check_eq("buf_off_stable", buf_off, eo);
      mem_ack = 1'b1;
      #1;
      check_eq("req_low_in_ack", mem_req, 1'b0);
      @(negedge clk);
      mem_ack = 1'b0;
      check_eq("burst_done", burst_done, 1'b1);
      check_eq("done_timing", done, (b == nb - 1) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check_eq("ready_after", cmd_ready, 1'b1);
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("burst_done_one_cycle", burst_done, 1'b0);
  endtask

  initial begin
    int rc;
    int bc;
    n_checks   = 0;
    n_fail     = 0;
    req_cycles = 0;
    bd_count   = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_rw     = 1'b0;
    cmd_addr   = 48'h0;
    cmd_len    = 32'h0;
    mem_ack    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset values
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 48'h0);
    check_eq("rst_mem_len", mem_len, 32'h0);
    check_eq("rst_buf_off", buf_off, 32'h0);
    check_eq("rst_flags", {mem_rw, burst_done, done, err}, 4'b0000);
    rst = 1'b0;

    // Zero length
    rc = req_cycles;
    bc = bd_count;
    send_cmd(1'b0, 48'h1000, 32'd0);
    @(negedge clk);
    check_eq("zero_done", done, 1'b1);
    check_eq("zero_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    check_eq("zero_ready", cmd_ready, 1'b1);
    check_eq("zero_done_off", done, 1'b0);
    check_eq("zero_no_req", req_cycles - rc, 0);
    check_eq("zero_no_bd", bd_count - bc, 0);

    // Single burst, write
    exp_burst(48'h2000, 32'd16, 32'd0);
    run_xfer(1'b1, 48'h2000, 32'd16, 2);

    // Size split, read
    exp_burst(48'h0,     32'd8192, 32'd0);
    exp_burst(48'h10000, 32'd8192, 32'd8192);
    exp_burst(48'h20000, 32'd3616, 32'd16384);
    bc = bd_count;
    run_xfer(1'b0, 48'h0, 32'd20000, 7);
    check_eq("split_bd_count", bd_count - bc, 3);

    // Page split
    exp_burst(48'hFFF8,  32'd1, 32'd0);
    exp_burst(48'h10000, 32'd2, 32'd1);
    run_xfer(1'b1, 48'hFFF8, 32'd3, 3);

    // Mid-page start limited by the page, then by what remains
    exp_burst(48'h8000,  32'd4096, 32'd0);
    exp_burst(48'h10000, 32'd5904, 32'd4096);
    run_xfer(1'b0, 48'h8000, 32'd10000, 2);

    // Misaligned descriptor
    rc = req_cycles;
    @(negedge clk);
    check_eq("mis_ready_before", cmd_ready, 1'b1);
    send_cmd(1'b0, 48'h4, 32'd5);
    @(negedge clk);
    check_eq("mis_err", err, 1'b1);
    check_eq("mis_ready", cmd_ready, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("mis_err_pulse", err, 1'b0);
    check_eq("mis_ready_after", cmd_ready, 1'b1);
    check_eq("mis_no_req", req_cycles - rc, 0);

    // Reset while a request is pending
    send_cmd(1'b1, 48'h3000, 32'd4);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_req", mem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_req", mem_req, 1'b0);
    check_eq("rst_mid_ready", cmd_ready, 1'b1);
    check_eq("rst_mid_addr", mem_addr, 48'h0);
    check_eq("rst_mid_len", mem_len, 32'h0);
    check_eq("rst_mid_off", buf_off, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Recovery after reset
    exp_burst(48'h5000, 32'd8, 32'd0);
    run_xfer(1'b1, 48'h5000, 32'd8, 4);

    check_eq("queues_drained", exp_len_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
